// File: rtl/ssd_pkg.sv
// ============================================================================
// Module      : ssd_pkg
// Description : Shared types and constants for the seven-segment scan
//               controller. Holds the logic-low segment patterns, bits {g..a}.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssd_pkg;

  typedef logic [6:0] seg_t;

  // All segments dark (logic-low bus, so every bit high).
  localparam seg_t SEG_OFF     = 7'h7F;
  // Shown for a nibble that cannot be decoded (X/unknown).
  localparam seg_t SEG_INVALID = 7'h36;

  // Hex digit glyphs 0..F, logic-low, {g,f,e,d,c,b,a}.
  localparam seg_t SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

`default_nettype wire

// File: rtl/ssd_segment_lut.sv
// ============================================================================
// Module      : ssd_segment_lut
// Description : Combinational hex nibble to logic-low segment decoder. A
//               nibble that matches no table entry (X/unknown) decodes to
//               SEG_INVALID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_segment_lut
  import ssd_pkg::*;
(
  input  logic [3:0] i_nibble,
  output seg_t       o_seg
);

  // Table lookup; an unknown nibble never compares equal, so it keeps the default.
  always_comb begin
    o_seg = SEG_INVALID;
    for (int k = 0; k < 16; k++) begin
      if (i_nibble == 4'(k)) begin
        o_seg = SEG_TABLE[k];
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ssd_scan_controller.sv
// ============================================================================
// Module      : ssd_scan_controller
// Description : Time-multiplexes NUM_DIGITS hex digits onto a shared
//               logic-low segment bus with active-low digit enables. A host
//               word is staged by Load and committed only at a frame boundary,
//               acknowledged by a one-cycle Ack.
//               Optional macro LEADING_ZERO_BLANK_EN: blank leading zero
//               digits (never digit 0) when a word is committed.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssd_scan_controller
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = $clog2(REFRESH_DIV)
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] Value,
  input  logic [NUM_DIGITS-1:0]   Blank,
  input  logic                    Load,
  output logic                    Ack,
  output logic                    Pending,
  output seg_t                    Segments,
  output logic [NUM_DIGITS-1:0]   DigitEn
);

  localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] stg_value_q, stg_value_d;
  logic [4*NUM_DIGITS-1:0] com_value_q, com_value_d;
  logic [NUM_DIGITS-1:0]   stg_blank_q, stg_blank_d;
  logic [NUM_DIGITS-1:0]   com_blank_q, com_blank_d;
  logic                    pending_q, pending_d;
  logic                    ack_q, ack_d;
  seg_t                    seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;

  logic                    w_slot_end;
  logic                    w_frame_end;
  logic                    w_commit;
  logic [NUM_DIGITS-1:0]   w_auto_blank;
  logic [3:0]              w_nibble;
  logic                    w_blank;
  seg_t                    w_seg;

  // Slot counter and digit index; the frame ends on the last slot of the last digit.
  always_comb begin
    w_slot_end  = (cnt_q == CNT_LAST);
    w_frame_end = w_slot_end && (idx_q == IDX_LAST);
    cnt_d       = w_slot_end ? '0 : cnt_q + 1'b1;
    idx_d       = idx_q;
    if (w_slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // Leading-zero mask derived from the staged word, applied as it is committed.
  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic zero_run;
    zero_run     = 1'b1;
    w_auto_blank = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_run        = zero_run && (stg_value_q[4*k +: 4] == 4'h0);
      w_auto_blank[k] = zero_run;
    end
`else
    w_auto_blank = '0;
`endif
  end

  // Staging and commit: a Load in the commit cycle re-arms Pending with the newer word.
  always_comb begin
    w_commit    = w_frame_end && pending_q;
    stg_value_d = stg_value_q;
    stg_blank_d = stg_blank_q;
    com_value_d = com_value_q;
    com_blank_d = com_blank_q;
    pending_d   = pending_q;
    ack_d       = w_commit;
    if (w_commit) begin
      com_value_d = stg_value_q;
      com_blank_d = stg_blank_q | w_auto_blank;
      pending_d   = 1'b0;
    end
    if (Load) begin
      stg_value_d = Value;
      stg_blank_d = Blank;
      pending_d   = 1'b1;
    end
  end

  // Select the committed nibble and blank flag for the digit currently being scanned.
  always_comb begin
    w_nibble = '0;
    w_blank  = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        w_nibble = com_value_q[4*k +: 4];
        w_blank  = com_blank_q[k];
      end
    end
  end

  ssd_segment_lut u_lut (
    .i_nibble (w_nibble),
    .o_seg    (w_seg)
  );

  // Next segment/enable pattern; a blanked digit keeps its enable off too.
  always_comb begin
    seg_d = w_blank ? SEG_OFF : w_seg;
    en_d  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((idx_q == IDX_W'(k)) && !w_blank) begin
        en_d[k] = 1'b0;
      end
    end
  end

  // State and output registers with synchronous reset to a dark display.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      stg_value_q <= '0;
      com_value_q <= '0;
      stg_blank_q <= '1;
      com_blank_q <= '1;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
      seg_q       <= SEG_OFF;
      en_q        <= '1;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      stg_value_q <= stg_value_d;
      com_value_q <= com_value_d;
      stg_blank_q <= stg_blank_d;
      com_blank_q <= com_blank_d;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      seg_q       <= seg_d;
      en_q        <= en_d;
    end
  end

  assign Ack      = ack_q;
  assign Pending  = pending_q;
  assign Segments = seg_q;
  assign DigitEn  = en_q;

endmodule

`default_nettype wire
